// File: rtl/shift_sequencer.sv
// Feeds a combinational right shifter/rotator and collects its result.
// SRL/SRA/SLL/ROR/ROL requests are mapped onto right-only shift/rotate
// commands, the shifter output is masked or sign-filled, and the result is
// registered with N/Z/C flags and held until the consumer takes it.

module shift_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    // request side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [2:0]       in_op,
    // shifter side
    output logic [WIDTH-1:0] sh_a,
    output logic [AW-1:0]    sh_amt,
    output logic             sh_rot,
    input  logic [WIDTH-1:0] sh_y,
    // result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_err
);

    localparam logic [2:0] OpSrl = 3'b000;
    localparam logic [2:0] OpSra = 3'b001;
    localparam logic [2:0] OpSll = 3'b010;
    localparam logic [2:0] OpRor = 3'b011;
    localparam logic [2:0] OpRol = 3'b100;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;

    logic [AW-1:0]    r_amt;
    logic [2:0]       r_op;

    logic [AW-1:0]    w_left_amt;
    logic [AW-1:0]    w_acc_amt;
    logic             w_acc_rot;
    logic             w_accept;

    logic [WIDTH-1:0] w_ones;
    logic [AW-1:0]    w_idx_right;
    logic [AW-1:0]    w_idx_left;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_err;

    assign w_accept = (r_state == StIdle) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> EXEC -> DONE -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (in_valid) w_state_next = StExec;
            StExec:  w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
    end

    // Command translation; left ops become right rotates by (w - n) mod w
    always_comb begin
        w_left_amt = (in_amt == '0) ? '0 : AW'(WIDTH - 32'(in_amt));
        w_acc_amt  = '0;
        w_acc_rot  = 1'b0;
        case (in_op)
            OpSrl, OpSra: begin
                w_acc_amt = in_amt;
                w_acc_rot = 1'b0;
            end
            OpRor: begin
                w_acc_amt = in_amt;
                w_acc_rot = 1'b1;
            end
            OpSll, OpRol: begin
                w_acc_amt = w_left_amt;
                w_acc_rot = 1'b1;
            end
            default: begin
                w_acc_amt = '0;
                w_acc_rot = 1'b0;
            end
        endcase
    end

    // Latch the request and drive the shifter; sh_a doubles as the operand copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a   <= '0;
            sh_amt <= '0;
            sh_rot <= 1'b0;
            r_amt  <= '0;
            r_op   <= '0;
        end else if (w_accept) begin
            sh_a   <= in_data;
            sh_amt <= w_acc_amt;
            sh_rot <= w_acc_rot;
            r_amt  <= in_amt;
            r_op   <= in_op;
        end
    end

    // Post-process the shifter output and pick the carry bit
    always_comb begin
        w_ones      = '1;
        w_idx_right = AW'(32'(r_amt) - 32'd1);
        w_idx_left  = AW'(WIDTH - 32'(r_amt));
        w_result    = sh_y;
        w_carry     = 1'b0;
        w_err       = 1'b0;
        case (r_op)
            OpSrl, OpRor: begin
                if (r_amt != '0) w_carry = sh_a[w_idx_right];
            end
            OpSra: begin
                w_result = sh_y | (sh_a[WIDTH-1] ? ~(w_ones >> r_amt) : '0);
                if (r_amt != '0) w_carry = sh_a[w_idx_right];
            end
            OpRol: begin
                if (r_amt != '0) w_carry = sh_a[w_idx_left];
            end
            OpSll: begin
                // rotate-left image with the wrapped-in low bits cleared
                w_result = sh_y & (w_ones << r_amt);
                if (r_amt != '0) w_carry = sh_a[w_idx_left];
            end
            default: begin
                w_result = sh_a;
                w_err    = 1'b1;
            end
        endcase
    end

    // Result register, loaded at the end of EXEC and held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_n    <= 1'b0;
            out_z    <= 1'b0;
            out_c    <= 1'b0;
            out_err  <= 1'b0;
        end else if (r_state == StExec) begin
            out_data <= w_result;
            out_n    <= w_result[WIDTH-1];
            out_z    <= (w_result == '0);
            out_c    <= w_carry;
            out_err  <= w_err;
        end
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Upstream feeder and result collector for the combinational right shifter/rotator (data in, amount, shift/rotate select, result out).
- Accepts shift requests over a valid/ready handshake and translates SRL, SRA, SLL, ROR and ROL into right-only shift/rotate commands.
- Drives the shifter and post-processes its output with masking and sign fill.
- Registers the result with N, Z and C flags and holds it under backpressure for the ALU writeback path.

Parameters:
WIDTH, 16, datapath width; must match the shifter's width.
AW, $clog2(WIDTH), width of the shift-amount field.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request present.
in_ready  output  1  block can accept a request.
in_data  input  WIDTH  operand.
in_amt  input  AW  shift amount n, 0..WIDTH-1.
in_op  input  3  000 SRL, 001 SRA, 010 SLL, 011 ROR, 100 ROL, others illegal.
sh_a  output  WIDTH  operand to shifter.
sh_amt  output  AW  right amount to shifter.
sh_rot  output  1  0 = logical right shift (zero fill), 1 = right rotate.
sh_y  input  WIDTH  shifter result (combinational from sh_*).
out_valid  output  1  result present.
out_ready  input  1  consumer accepts result.
out_data  output  WIDTH  result.
out_n  output  1  out_data[WIDTH-1].
out_z  output  1  out_data == 0.
out_c  output  1  last bit shifted/rotated out.
out_err  output  1  illegal opcode.

Behaviour:
- Reset
  - Async on rst_n low: state IDLE.
  - sh_a, sh_amt, sh_rot, out_data, out_n, out_z, out_c, out_err, out_valid all 0.
  - in_ready = (state == IDLE); it reads 1 during and after reset.
  - An in-flight request is discarded on reset; no partial result appears.
- FSM: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: in_ready = 1. On a clock edge with in_valid = 1, latch the operand, n and op, and load sh_a/sh_amt/sh_rot (registered). Go to EXEC.
  - EXEC: in_ready = 0, out_valid = 0. sh_y is valid this cycle. At the next edge, capture the post-processed result and flags. Go to DONE.
  - DONE: out_valid = 1 and outputs stable. On an edge with out_ready = 1, go to IDLE and clear out_valid. While out_ready = 0, hold indefinitely; in_valid is ignored.
- Latency and throughput
  - Accept at edge E0; out_valid high from E1.
  - Earliest next accept is the edge after the out handshake, giving 1 request per 3 cycles.
- Command translation (n = latched amount, w = WIDTH)
  - SRL: rot = 0, amt = n. Result = sh_y.
  - SRA: rot = 0, amt = n. Result = sh_y OR (operand[w-1] ? ~({w{1}} >> n) : 0), i.e. the top n bits are sign-filled.
  - ROR: rot = 1, amt = n. Result = sh_y.
  - ROL: rot = 1, amt = (w - n) mod w. Result = sh_y.
  - SLL: rot = 1, amt = (w - n) mod w. Result = sh_y AND ({w{1}} << n), i.e. the low n bits are cleared.
  - n = 0: amt = 0 for every op, result = operand, c = 0. The mod-w wrap is required so that w is never truncated.
- Carry out_c
  - SRL, SRA, ROR: operand[n-1].
  - SLL, ROL: operand[w-n].
  - 0 when n = 0.
- Illegal opcode: sh_rot = 0, sh_amt = 0, result = operand, out_c = 0, out_err = 1. The request otherwise completes normally.
- out_n and out_z are computed from the final post-processed result, not from sh_y.
- sh_* hold their last values outside EXEC and change only on accept or reset.

Test Plan:
- WIDTH = 16, SRL, 0xF0F0, n = 4 -> sh_rot = 0, sh_amt = 4; out_data = 0x0F0F; c = 0, n = 0, z = 0; out_valid exactly 1 edge after accept.
- SRA, 0x8005, n = 3 -> out_data = 0xF000; c = 1 (operand[2]); out_n = 1.
- SLL, 0x00F1, n = 4 -> sh_rot = 1, sh_amt = 12; out_data = 0x0F10; c = 0. Follow with ROL, 0xF0F0, n = 4 -> out_data = 0x0F0F, c = 1.
- ROR, 0x0001, n = 1 -> out_data = 0x8000, c = 1, n = 1. Then SRL, 0x0000, n = 0 -> out_data = 0x0000, z = 1, c = 0, sh_amt = 0. Then op 111, 0x1234 -> out_data = 0x1234, out_err = 1.
- Hold out_ready = 0 for 5 cycles in DONE while pulsing in_valid -> out_valid, out_data and flags stay constant, in_ready = 0, nothing accepted. Raise out_ready -> IDLE next edge, then the next request is accepted.
- Assert rst_n = 0 asynchronously during EXEC -> out_valid, sh_a, sh_amt, sh_rot and all flags go to 0 immediately; after release in_ready = 1 and no stale result is ever presented.
